// File: rtl/tetris_pkg.sv
// tetris_pkg: command opcodes and sequencer states shared with the board datapath
package tetris_pkg;
  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_SPAWN  = 3'd1;
  localparam logic [2:0] OP_LEFT   = 3'd2;
  localparam logic [2:0] OP_RIGHT  = 3'd3;
  localparam logic [2:0] OP_ROTATE = 3'd4;
  localparam logic [2:0] OP_DOWN   = 3'd5;
  localparam logic [2:0] OP_LOCK   = 3'd6;
  typedef enum logic [2:0] {ST_IDLE, ST_SPAWN, ST_PLAY, ST_WAIT, ST_LOCK, ST_OVER} state_e;
endpackage

// File: rtl/arduino_input_sync.sv
// arduino_input_sync: synchronises the Arduino strobe and buttons into a one-cycle button strobe
module arduino_input_sync (
  input  logic       clock,
  input  logic       reset,
  input  logic       arduino_clock,
  input  logic [3:0] arduino_btn,
  output logic [3:0] btn_strobe
);
  logic [2:0] ck_q;
  logic [3:0] b1_q, b2_q;
  always_ff @(posedge clock)
    if (reset) begin
      ck_q <= '0;
      b1_q <= '0;
      b2_q <= '0;
    end else begin
      ck_q <= {ck_q[1:0], arduino_clock};
      b1_q <= arduino_btn;
      b2_q <= b1_q;
    end
  assign btn_strobe = (ck_q[1] && !ck_q[2]) ? b2_q : 4'd0;
endmodule

// File: rtl/tetris_game_sequencer.sv
// tetris_game_sequencer: arbitrates buttons and gravity into datapath commands and sequences the game
module tetris_game_sequencer
  import tetris_pkg::*;
#(
  parameter int GRAVITY_TICKS = 50000,
  parameter int SPEEDUP_STEP  = 3000,
  parameter int MIN_TICKS     = 5000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        arduino_clock,
  input  logic [3:0]  arduino_btn,
  output logic        cmd_valid,
  output logic [2:0]  cmd_op,
  input  logic        cmd_ready,
  input  logic        resp_valid,
  input  logic        resp_ok,
  input  logic [2:0]  resp_lines,
  output logic        playing,
  output logic        game_over,
  output logic [3:0]  level,
  output logic [15:0] lines_total
);
  state_e state_q, state_d;
  logic cmd_valid_q, cmd_valid_d, acc_q, acc_d, playing_q, playing_d, over_q, over_d;
  logic start_q, start_p_q;
  logic [2:0] cmd_op_q, cmd_op_d, pick_op;
  logic [4:0] pend_q, pend_d, sel_q, sel_d, pick, sum;
  logic [15:0] grav_q, grav_d, lines_q, lines_d;
  logic [16:0] tot;
  logic [3:0] level_q, level_d, lvl_lines_q, lvl_lines_d, btn_strobe;
  logic run, live, grav_hit, fire, resp_here, start_edge;
  int period;
  arduino_input_sync u_sync (
    .clock(clock),
    .reset(reset),
    .arduino_clock(arduino_clock),
    .arduino_btn(arduino_btn),
    .btn_strobe(btn_strobe)
  );
  always_comb begin
    period = GRAVITY_TICKS - int'(level_q) * SPEEDUP_STEP;
    period = period < MIN_TICKS ? MIN_TICKS : period;
    run = state_q == ST_PLAY || state_q == ST_WAIT;
    live = run || state_q == ST_SPAWN || state_q == ST_LOCK;
    grav_hit = run && int'(grav_q) == period - 1;
    fire = cmd_valid_q && cmd_ready;
    resp_here = resp_valid && (acc_q || fire);
    start_edge = start_q && !start_p_q;
    pick = pend_q[4] ? 5'b10000 : pend_q[3] ? 5'b01000 : pend_q[2] ? 5'b00100 :
           pend_q[1] ? 5'b00010 : pend_q[0] ? 5'b00001 : 5'b00000;
    pick_op = pick[3] ? OP_ROTATE : pick[2] ? OP_LEFT : pick[1] ? OP_RIGHT : OP_DOWN;
    sum = {1'b0, lvl_lines_q} + {2'b0, resp_lines};
    tot = {1'b0, lines_q} + {14'b0, resp_lines};
    state_d = state_q;
    cmd_valid_d = cmd_valid_q && !fire;
    cmd_op_d = cmd_op_q;
    acc_d = (acc_q || fire) && !resp_here;
    sel_d = fire ? 5'b0 : sel_q;
    pend_d = (pend_q & ~(fire ? sel_q : 5'b0)) |
             (live ? {grav_hit, btn_strobe[2], btn_strobe[0], btn_strobe[1], btn_strobe[3]} : 5'b0);
    grav_d = run ? (grav_hit ? 16'd0 : grav_q + 16'd1) : grav_q;
    level_d = level_q;
    lvl_lines_d = lvl_lines_q;
    lines_d = lines_q;
    case (state_q)
      ST_IDLE, ST_OVER: if (start_edge) begin
        state_d = ST_SPAWN;
        cmd_valid_d = 1'b1;
        cmd_op_d = OP_SPAWN;
        pend_d = 5'b0;
        grav_d = 16'd0;
        level_d = 4'd0;
        lvl_lines_d = 4'd0;
        lines_d = 16'd0;
      end
      ST_SPAWN: if (resp_here) state_d = resp_ok ? ST_PLAY : ST_OVER;
      ST_PLAY, ST_WAIT: if (resp_here) begin
        state_d = (cmd_op_q == OP_DOWN && !resp_ok) ? ST_LOCK : ST_PLAY;
        cmd_valid_d = state_d == ST_LOCK;
        cmd_op_d = state_d == ST_LOCK ? OP_LOCK : cmd_op_q;
      end else if (fire) begin
        state_d = ST_WAIT;
      end else if (state_q == ST_PLAY && !cmd_valid_q && pend_q != 5'b0) begin
        cmd_valid_d = 1'b1;
        cmd_op_d = pick_op;
        sel_d = pick;
      end
      ST_LOCK: if (resp_here) begin
        state_d = ST_SPAWN;
        cmd_valid_d = 1'b1;
        cmd_op_d = OP_SPAWN;
        grav_d = 16'd0;
        pend_d[3:0] = 4'b0;
        lvl_lines_d = sum >= 5'd10 ? 4'(sum - 5'd10) : sum[3:0];
        level_d = (sum >= 5'd10 && level_q != 4'd15) ? level_q + 4'd1 : level_q;
        lines_d = tot[16] ? 16'hFFFF : tot[15:0];
      end
      default: ;
    endcase
    playing_d = state_d inside {ST_SPAWN, ST_PLAY, ST_WAIT, ST_LOCK};
    over_d = state_d == ST_OVER;
  end
  always_ff @(posedge clock)
    if (reset) begin
      state_q <= ST_IDLE;
      cmd_valid_q <= 1'b0;
      cmd_op_q <= OP_NOP;
      acc_q <= 1'b0;
      sel_q <= '0;
      pend_q <= '0;
      grav_q <= '0;
      level_q <= '0;
      lvl_lines_q <= '0;
      lines_q <= '0;
      playing_q <= 1'b0;
      over_q <= 1'b0;
      start_q <= 1'b0;
      start_p_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_op_q <= cmd_op_d;
      acc_q <= acc_d;
      sel_q <= sel_d;
      pend_q <= pend_d;
      grav_q <= grav_d;
      level_q <= level_d;
      lvl_lines_q <= lvl_lines_d;
      lines_q <= lines_d;
      playing_q <= playing_d;
      over_q <= over_d;
      start_q <= start;
      start_p_q <= start_q;
    end
  assign cmd_valid = cmd_valid_q;
  assign cmd_op = cmd_op_q;
  assign playing = playing_q;
  assign game_over = over_q;
  assign level = level_q;
  assign lines_total = lines_q;
endmodule

// File: tb/tb_tetris_game_sequencer.sv
// tb_tetris_game_sequencer: directed and randomized play checked against a behavioural game model
module tb_tetris_game_sequencer;
  import tetris_pkg::*;
  logic clock = 1'b0;
  logic reset, start, arduino_clock, cmd_ready, resp_valid, resp_ok, cmd_valid, playing, game_over;
  logic [3:0] arduino_btn, level;
  logic [2:0] cmd_op, resp_lines;
  logic [15:0] lines_total;
  int tests = 0, fails = 0, cyc_n = 0, rcnt = 0, rdel = 2;
  logic rok = 1'b1, down_ok = 1'b1, spawn_ok = 1'b1, inject = 1'b0;
  logic [2:0] rlines = 3'd0, lines_next = 3'd0;
  int ops[$], tms[$];
  tetris_game_sequencer #(.GRAVITY_TICKS(20), .SPEEDUP_STEP(4), .MIN_TICKS(8)) dut (
    .clock(clock), .reset(reset), .start(start),
    .arduino_clock(arduino_clock), .arduino_btn(arduino_btn),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
    .resp_valid(resp_valid), .resp_ok(resp_ok), .resp_lines(resp_lines),
    .playing(playing), .game_over(game_over), .level(level), .lines_total(lines_total)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask
  task automatic cyc();
    resp_valid = 1'b0;
    if (rcnt > 0) begin
      rcnt--;
      if (rcnt == 0) begin
        resp_valid = 1'b1;
        resp_ok = rok;
        resp_lines = rlines;
      end
    end
    if (inject) begin
      resp_valid = 1'b1;
      resp_ok = 1'b1;
      inject = 1'b0;
    end
    if (cmd_valid === 1'b1 && cmd_ready) begin
      ops.push_back(int'(cmd_op));
      tms.push_back(cyc_n);
      rcnt = rdel;
      rok = cmd_op == OP_DOWN ? down_ok : cmd_op == OP_SPAWN ? spawn_ok : 1'b1;
      rlines = cmd_op == OP_LOCK ? lines_next : 3'd0;
    end
    @(negedge clock);
    cyc_n++;
  endtask
  task automatic exp_op(input string tag, input int op, output int t);
    int n;
    n = 0;
    while (ops.size() == 0 && n < 300) begin
      cyc();
      n++;
    end
    if (ops.size() == 0) begin
      t = -1;
      chk(tag, 32'hFFFF_FFFF, op);
    end else begin
      t = tms.pop_front();
      chk(tag, ops.pop_front(), op);
    end
  endtask
  task automatic press(input logic [3:0] b);
    arduino_btn = b;
    cyc();
    arduino_clock = 1'b1;
    repeat (4) cyc();
    arduino_clock = 1'b0;
    arduino_btn = 4'd0;
    repeat (2) cyc();
  endtask
  task automatic pulse_start();
    start = 1'b1;
    cyc();
    cyc();
    start = 1'b0;
    cyc();
  endtask
  initial begin
    int t0, t1, t2, n, total, lv, per, l;
    int exp_q[$];
    logic [2:0] m;
    logic ok;
    reset = 1'b1; start = 1'b0; arduino_clock = 1'b0; arduino_btn = 4'd0;
    cmd_ready = 1'b1; resp_valid = 1'b0; resp_ok = 1'b0; resp_lines = 3'd0;
    @(negedge clock);
    repeat (3) cyc();
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_cmd_op", cmd_op, 0);
    chk("rst_playing", playing, 0);
    chk("rst_game_over", game_over, 0);
    chk("rst_level", level, 0);
    chk("rst_lines", lines_total, 0);
    reset = 1'b0;
    pulse_start();
    exp_op("spawn", OP_SPAWN, t0);
    exp_op("grav_first", OP_DOWN, t1);
    chk("playing", playing, 1);
    chk("grav_first_window", (t1 - t0 - 2) >= 20 && (t1 - t0 - 2) <= 22, 1);
    exp_op("grav_second", OP_DOWN, t2);
    chk("grav_period_l0", t2 - t1, 20);
    press(4'b0101);
    exp_op("btn_rotate", OP_ROTATE, t0);
    exp_op("btn_left", OP_LEFT, t0);
    exp_op("btn_no_dup", OP_DOWN, t1);
    chk("grav_after_btn", t1 - t2, 20);
    for (int i = 0; i < 3; i++) begin
      m = 3'($urandom_range(1, 7));
      exp_q.delete();
      if (m[2]) exp_q.push_back(OP_ROTATE);
      if (m[0]) exp_q.push_back(OP_LEFT);
      if (m[1]) exp_q.push_back(OP_RIGHT);
      exp_q.push_back(OP_DOWN);
      press({1'b0, m});
      foreach (exp_q[k]) exp_op("rand_btn", exp_q[k], t0);
    end
    rdel = 25;
    exp_op("grav_slow", OP_DOWN, t0);
    rdel = 2;
    press(4'b0100);
    cmd_ready = 1'b0;
    n = 0;
    while (cmd_valid !== 1'b1 && n < 60) begin
      cyc();
      n++;
    end
    chk("hold_op", cmd_op, OP_DOWN);
    ok = 1'b1;
    repeat (5) begin
      cyc();
      if (cmd_valid !== 1'b1 || cmd_op !== OP_DOWN) ok = 1'b0;
    end
    chk("hold_stable", ok, 1);
    cmd_ready = 1'b1;
    exp_op("hold_down", OP_DOWN, t0);
    exp_op("hold_rotate", OP_ROTATE, t0);
    total = 0;
    for (int i = 0; i < 5; i++) begin
      l = i < 3 ? 4 : int'($urandom_range(0, 4));
      down_ok = 1'b0;
      lines_next = 3'(l);
      exp_op("lock_down", OP_DOWN, t0);
      exp_op("lock_cmd", OP_LOCK, t0);
      exp_op("lock_spawn", OP_SPAWN, t0);
      total += l;
      lv = total / 10 > 15 ? 15 : total / 10;
      per = 20 - 4 * lv < 8 ? 8 : 20 - 4 * lv;
      chk("lines_total", lines_total, total);
      chk("level", level, lv);
      down_ok = 1'b1;
      exp_op("grav_a", OP_DOWN, t1);
      exp_op("grav_b", OP_DOWN, t2);
      chk("grav_period", t2 - t1, per);
    end
    down_ok = 1'b0;
    spawn_ok = 1'b0;
    lines_next = 3'($urandom_range(0, 4));
    exp_op("over_down", OP_DOWN, t0);
    exp_op("over_lock", OP_LOCK, t0);
    exp_op("over_spawn", OP_SPAWN, t0);
    repeat (3) cyc();
    chk("over_game_over", game_over, 1);
    chk("over_playing", playing, 0);
    ops.delete();
    tms.delete();
    press(4'b1111);
    repeat (30) cyc();
    chk("over_ignored", ops.size(), 0);
    chk("over_cmd_valid", cmd_valid, 0);
    spawn_ok = 1'b1;
    down_ok = 1'b1;
    pulse_start();
    exp_op("restart", OP_SPAWN, t0);
    chk("restart_level", level, 0);
    chk("restart_lines", lines_total, 0);
    repeat (3) cyc();
    chk("restart_playing", playing, 1);
    chk("restart_game_over", game_over, 0);
    cmd_ready = 1'b0;
    n = 0;
    while (cmd_valid !== 1'b1 && n < 60) begin
      cyc();
      n++;
    end
    chk("midrst_pre_valid", cmd_valid, 1);
    reset = 1'b1;
    cyc();
    chk("midrst_cmd_valid", cmd_valid, 0);
    chk("midrst_playing", playing, 0);
    reset = 1'b0;
    rcnt = 0;
    cmd_ready = 1'b1;
    inject = 1'b1;
    ok = 1'b1;
    repeat (10) begin
      cyc();
      if (cmd_valid !== 1'b0 || playing !== 1'b0) ok = 1'b0;
    end
    chk("late_resp_ignored", ok, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
